// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its clients.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes are opaque to the arbiter; requesters and benches use these names.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_CMP  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_CPL  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_SHL0 = 4'h8;
  localparam logic [3:0] OP_SHL1 = 4'h9;
  localparam logic [3:0] OP_SHLC = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_SHR0 = 4'hC;
  localparam logic [3:0] OP_SHR1 = 4'hD;
  localparam logic [3:0] OP_SHRC = 4'hE;
  localparam logic [3:0] OP_ROR  = 4'hF;

  // Latency counter width; covers ALU_LAT up to 7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side and ALU-side signal bundle of the shared-ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned MW = 4
);
  logic          req0, cin0, ack0, of0;
  logic [W-1:0]  a0, b0, res0;
  logic [MW-1:0] m0;

  logic          req1, cin1, ack1, of1;
  logic [W-1:0]  a1, b1, res1;
  logic [MW-1:0] m1;

  logic [W-1:0]  alu_a, alu_b, alu_r;
  logic [MW-1:0] alu_m;
  logic          alu_cin, alu_of;

  logic          busy, owner;

  modport slave (
    input  req0, a0, b0, m0, cin0,
    input  req1, a1, b1, m1, cin1,
    input  alu_r, alu_of,
    output ack0, res0, of0, ack1, res1, of1,
    output alu_a, alu_b, alu_m, alu_cin,
    output busy, owner
  );

  modport master (
    output req0, a0, b0, m0, cin0,
    output req1, a1, b1, m1, cin1,
    output alu_r, alu_of,
    input  ack0, res0, of0, ack1, res1, of1,
    input  alu_a, alu_b, alu_m, alu_cin,
    input  busy, owner
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on contention the requester other than owner wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic gnt_valid,
  output logic gnt_idx
);
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      gnt_idx = ~owner;
    end else if (req1) begin
      gnt_idx = 1'b1;
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered-latency ALU between two requesters, round-robin,
// returning result/flag to the winner with a one-cycle ack.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned MW      = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic Clk,
  input  logic nReset,
  alu_share_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d, busy_q, busy_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             of0_q, of0_d, of1_q, of1_d;
  logic [W-1:0]     res0_q, res0_d, res1_q, res1_d;
  logic [W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [MW-1:0]    alu_m_q, alu_m_d;
  logic             alu_cin_q, alu_cin_d;
  logic             gnt_valid, gnt_idx;

  rr_arb2 u_arb (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .owner     (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    of0_d     = of0_q;
    of1_d     = of1_q;
    res0_d    = res0_q;
    res1_d    = res1_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_m_d   = alu_m_q;
    alu_cin_d = alu_cin_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d   = gnt_idx;
          alu_a_d   = gnt_idx ? bus.a1   : bus.a0;
          alu_b_d   = gnt_idx ? bus.b1   : bus.b0;
          alu_m_d   = gnt_idx ? bus.m1   : bus.m0;
          alu_cin_d = gnt_idx ? bus.cin1 : bus.cin0;
          cnt_d     = LAT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Capture on the edge after the counter hits zero: ALU_LAT+1 edges from grant.
        if (cnt_q == '0) begin
          if (owner_q) begin
            res1_d = bus.alu_r;
            of1_d  = bus.alu_of;
            ack1_d = 1'b1;
          end else begin
            res0_d = bus.alu_r;
            of0_d  = bus.alu_of;
            ack0_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b1;
      busy_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      of0_q     <= 1'b0;
      of1_q     <= 1'b0;
      res0_q    <= '0;
      res1_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_m_q   <= '0;
      alu_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      of0_q     <= of0_d;
      of1_q     <= of1_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_m_q   <= alu_m_d;
      alu_cin_q <= alu_cin_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.res0    = res0_q;
  assign bus.res1    = res1_q;
  assign bus.of0     = of0_q;
  assign bus.of1     = of1_q;
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_m   = alu_m_q;
  assign bus.alu_cin = alu_cin_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 4-bit ALU/accumulator datapath between two requesters.
- Arbitrates round-robin and drives the selected requester's operands and opcode onto the ALU.
- Waits out the ALU's registered latency, then returns the result and overflow flag to the winner with a one-cycle ack.
- Sits between the two command sources (e.g. two sequencers) and the single ALU instance.

Parameters:
- W, 4: operand/result width.
- MW, 4: opcode (mode) width.
- ALU_LAT, 1: clock edges from ALU input change to valid alu_r/alu_of; legal range 1..7.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- nReset  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 request; level, held until ack0.
- a0, b0  in  W  requester 0 operands; stable while req0 high.
- m0  in  MW  requester 0 opcode.
- cin0  in  1  requester 0 carry-in.
- ack0  out  1  one-cycle pulse; res0/of0 valid this cycle.
- res0  out  W  requester 0 result.
- of0  out  1  requester 0 overflow/carry/borrow flag.
- req1, a1, b1, m1, cin1, ack1, res1, of1  same as above for requester 1.
- alu_a, alu_b  out  W  registered operands to ALU.
- alu_m  out  MW  registered opcode to ALU.
- alu_cin  out  1  registered carry-in to ALU.
- alu_r  in  W  ALU result.
- alu_of  in  1  ALU overflow flag.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  index of current or last granted requester.

Behaviour:
Reset (nReset sampled low at a rising edge):
- State goes to IDLE.
- ack0/ack1, busy, res0/res1, of0/of1, alu_a/alu_b/alu_m/alu_cin all go to 0.
- owner goes to 1, so requester 0 wins the first contention.
- An in-flight operation is discarded and no ack is produced for it.

FSM states: IDLE, WAIT, DONE.

IDLE:
- If no req is high, stay in IDLE.
- If exactly one req is high, grant it.
- If both are high, grant the requester not equal to owner (round-robin).
- On grant, at the same edge:
  - owner takes the granted index;
  - the selected a/b/m/cin are registered onto alu_*;
  - the down-counter is loaded with ALU_LAT;
  - state goes to WAIT.

WAIT:
- Counter decrements each edge.
- When the counter reaches 0, at that edge:
  - alu_r/alu_of are captured into res/of of the owner only;
  - the owner's ack is set for one cycle;
  - state goes to DONE.
- The non-owner's res/of hold their previous values.

DONE:
- ack drops at the next edge and state returns to IDLE.
- No new grant is taken in DONE, so there is one bubble cycle between operations.

Latency and handshake:
- Latency from the grant edge to the ack cycle is ALU_LAT+1 edges. With ALU_LAT=1, ack is high in the 2nd cycle after the grant edge.
- alu_* hold their values from grant until the next grant; they do not return to 0 between operations.
- The arbiter does not check that operands stay stable during WAIT; holding them stable until ack is the requester's obligation.
- A req still high in IDLE after its ack is treated as a new request.
- A requester may drop req only after ack. A drop before ack does not cancel the operation; the ack still fires.
- A req rising while busy is held pending and is arbitrated at the next IDLE.

Arbitration and data rules:
- With both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- The arbiter does no width extension or arithmetic; data passes through unmodified.
- Opcode values are opaque to the arbiter.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - opcode constants (ADD=4'h0, SUB=4'h1, CMP=4'h2, AND=4'h3, OR=4'h4, CPL=4'h5, INC=4'h6, DEC=4'h7, SHL0..ROR=4'h8..4'hF), for benches and requesters.
- One sub-module: rr_arb2, a combinational two-input round-robin pick from req0, req1 and owner.
- Counter and FSM stay in the top module.

Test Plan:
1. Reset then idle: nReset=0 for 2 cycles, then 1 with no req -> all outputs 0, owner=1, busy=0, no ack.
2. Single request, ALU_LAT=1: req0 with a0=4'hF, b0=4'h1, m0=ADD; ALU model returns r=4'h0, of=1 -> alu_a=F, alu_b=1 after the grant edge; ack0 in the 2nd cycle after grant with res0=0, of0=1; ack1 stays 0.
3. Contention: req0 and req1 rise in the same cycle after reset -> requester 0 is served first, then 1 (ack1 ALU_LAT+3 cycles after ack0); with both held high, grants alternate for 6 operations.
4. Late request: req1 asserted while busy serving 0 -> served immediately after DONE; res0/of0 unchanged by 1's operation.
5. Reset mid-operation: nReset=0 during WAIT -> no ack is ever produced for that operation; all outputs 0; after release, a pending req0 is granted first.
6. Latency parameter: ALU_LAT=3 with a 3-stage ALU model, a1=4'h7, b1=4'hC, m1=AND -> ack1 exactly 4 edges after grant with res1=4'h4.
